// File: rtl/rom_share_ctrl.sv
// Boot sequencer and port arbiter for the MCU program ROM: holds the core in reset, takes a
// byte-stream download, then shares the single BRAM port (download write > debug read > core fetch).
module rom_share_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 8,
  parameter int ROM_WORDS = 2048,
  parameter int RST_HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_start,
  input  logic              dl_end,
  input  logic              dl_valid,
  output logic              dl_ready,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [DATA_W-1:0] dl_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_free,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_reset,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_we,
  output logic [DATA_W-1:0] rom_wdata,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              busy,
  output logic              err,
  output logic [11:0]       byte_count
);

  typedef enum logic [1:0] {HOLD, RUN, LOAD} state_t;

  localparam int CNT_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_HOLD);
  // One extra bit so a full 2**ADDR_W ROM compares correctly.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(ROM_WORDS);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              accept, in_range, wr, grant;
  logic [DATA_W-1:0] dbg_hold;

  always_comb begin
    in_range = ({1'b0, dl_addr} < ADDR_LIMIT);
    accept   = (state == LOAD) && dl_valid;
    wr       = accept && in_range;
    // The ack cycle doubles as the single outstanding-read slot, so no grant then.
    grant    = dbg_req && !dbg_ack && !wr && ((state != RUN) || cpu_free);

    rom_addr = cpu_addr;
    rom_we   = 1'b0;
    if (wr) begin
      rom_addr = dl_addr;
      rom_we   = 1'b1;
    end else if (grant) begin
      rom_addr = dbg_addr;
    end

    rom_wdata = dl_data;
    cpu_data  = rom_rdata;
    dl_ready  = (state == LOAD);
    busy      = (state != RUN);
    dbg_data  = dbg_ack ? rom_rdata : dbg_hold;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      HOLD: begin
        if (cnt <= CNT_W'(1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RUN: ;
      LOAD: begin
        if (dl_end) begin
          state_nx = HOLD;
          cnt_nx   = CNT_INIT;
        end
      end
      default: begin
        state_nx = HOLD;
        cnt_nx   = CNT_INIT;
      end
    endcase
    if (dl_start) begin
      state_nx = LOAD;
      cnt_nx   = CNT_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HOLD;
      cnt        <= CNT_INIT;
      cpu_reset  <= 1'b1;
      dbg_ack    <= 1'b0;
      dbg_hold   <= '0;
      err        <= 1'b0;
      byte_count <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cpu_reset <= (state_nx != RUN);
      dbg_ack   <= grant;
      if (dbg_ack) begin
        dbg_hold <= rom_rdata;
      end
      if (accept && !in_range) begin
        err <= 1'b1;
      end
      if (dl_start) begin
        byte_count <= '0;
      end else if (wr && (byte_count != 12'hFFF)) begin
        byte_count <= byte_count + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_rom_share_ctrl.sv
// Directed bench for rom_share_ctrl: boot hold, download, range error, debug arbitration, reset abort.
module tb_rom_share_ctrl;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          dl_start, dl_end, dl_valid, dl_ready;
  logic [AW-1:0] dl_addr, cpu_addr, dbg_addr, rom_addr;
  logic [DW-1:0] dl_data, cpu_data, dbg_data, rom_wdata, rom_rdata;
  logic          cpu_free, cpu_reset, dbg_req, dbg_ack, rom_we, busy, err;
  logic [11:0]   byte_count;

  int errors = 0;
  int checks = 0;

  rom_share_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ROM_WORDS(2048), .RST_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .dl_start(dl_start), .dl_end(dl_end), .dl_valid(dl_valid), .dl_ready(dl_ready),
    .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_addr(cpu_addr), .cpu_free(cpu_free), .cpu_data(cpu_data), .cpu_reset(cpu_reset),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .rom_addr(rom_addr), .rom_we(rom_we), .rom_wdata(rom_wdata), .rom_rdata(rom_rdata),
    .busy(busy), .err(err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // BRAM model with one-cycle registered read
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (rom_we) mem[rom_addr] <= rom_wdata;
    rom_rdata <= mem[rom_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [AW-1:0] dl_tbl_a [3];
  logic [DW-1:0] dl_tbl_d [3];

  initial begin
    dl_tbl_a[0] = 12'h000; dl_tbl_d[0] = 8'hA5;
    dl_tbl_a[1] = 12'h001; dl_tbl_d[1] = 8'h3C;
    dl_tbl_a[2] = 12'h7FF; dl_tbl_d[2] = 8'hFF;

    reset = 1'b1; dl_start = 0; dl_end = 0; dl_valid = 0; dl_addr = '0; dl_data = '0;
    cpu_addr = '0; cpu_free = 0; dbg_req = 0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 1);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_dbg_data", dbg_data, 0);
    chk("rst_err", err, 0);
    chk("rst_byte_count", byte_count, 0);
    reset = 1'b0;

    // boot hold: high through 4 cycles after release, falls with busy on the 4th edge
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("boot_cpu_reset", cpu_reset, (i < 4) ? 1 : 0);
      chk("boot_busy", busy, (i < 4) ? 1 : 0);
    end

    // download three bytes, last one together with dl_end
    dl_start = 1;
    @(negedge clk);
    dl_start = 0;
    chk("load_cpu_reset", cpu_reset, 1);
    chk("load_dl_ready", dl_ready, 1);
    for (int k = 0; k < 3; k++) begin
      dl_valid = 1; dl_addr = dl_tbl_a[k]; dl_data = dl_tbl_d[k]; dl_end = (k == 2);
      #1;
      chk("dl_we", rom_we, 1);
      chk("dl_rom_addr", rom_addr, dl_tbl_a[k]);
      @(negedge clk);
    end
    dl_valid = 0; dl_end = 0;
    #1;
    chk("dl_we_after", rom_we, 0);
    chk("dl_byte_count", byte_count, 3);
    chk("dl_ready_hold", dl_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("dl_end_cpu_reset", cpu_reset, (i < 4) ? 1 : 0);
    end

    // out-of-range byte dropped, err sticky
    dl_start = 1;
    @(negedge clk);
    dl_start = 0;
    chk("err_bc_clear", byte_count, 0);
    dl_valid = 1; dl_addr = 12'h800; dl_data = 8'h77;
    #1;
    chk("oor_we", rom_we, 0);
    chk("oor_ready", dl_ready, 1);
    @(negedge clk);
    chk("oor_err", err, 1);
    chk("oor_byte_count", byte_count, 0);
    dl_addr = 12'h002; dl_data = 8'h11;
    #1;
    chk("inr_we", rom_we, 1);
    @(negedge clk);
    dl_valid = 0;
    chk("inr_byte_count", byte_count, 1);
    dl_end = 1;
    @(negedge clk);
    dl_end = 0;
    repeat (4) @(negedge clk);
    chk("run_busy", busy, 0);

    // debug read in RUN waits for cpu_free
    dbg_req = 1; dbg_addr = 12'h001; cpu_addr = 12'h010; cpu_free = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("dbg_wait_addr", rom_addr, 12'h010);
      chk("dbg_wait_ack", dbg_ack, 0);
      @(negedge clk);
    end
    cpu_free = 1;
    #1;
    chk("dbg_grant_addr", rom_addr, 12'h001);
    @(negedge clk);
    #1;
    chk("dbg_ack", dbg_ack, 1);
    chk("dbg_data", dbg_data, 8'h3C);
    chk("dbg_ack_no_regrant", rom_addr, 12'h010);
    dbg_req = 0; cpu_free = 0;
    @(negedge clk);
    chk("dbg_ack_pulse", dbg_ack, 0);
    chk("dbg_data_held", dbg_data, 8'h3C);

    // LOAD: download write beats debug every cycle
    dl_start = 1;
    @(negedge clk);
    dl_start = 0;
    dbg_req = 1; dbg_addr = 12'h002;
    for (int k = 0; k < 3; k++) begin
      dl_valid = 1; dl_addr = 12'h010 + AW'(k); dl_data = 8'(k);
      #1;
      chk("cont_we", rom_we, 1);
      chk("cont_addr", rom_addr, 12'h010 + AW'(k));
      chk("cont_no_ack", dbg_ack, 0);
      @(negedge clk);
    end
    dl_valid = 0;
    #1;
    chk("cont_grant_addr", rom_addr, 12'h002);
    chk("cont_grant_we", rom_we, 0);
    @(negedge clk);
    chk("cont_ack", dbg_ack, 1);
    chk("cont_data", dbg_data, 8'h11);
    chk("err_sticky", err, 1);
    chk("cont_byte_count", byte_count, 3);
    dbg_req = 0;
    dl_end = 1;
    @(negedge clk);
    dl_end = 0;
    repeat (4) @(negedge clk);
    chk("run2_cpu_reset", cpu_reset, 0);

    // start+end together in RUN: start wins
    dl_start = 1; dl_end = 1;
    @(negedge clk);
    dl_start = 0; dl_end = 0;
    chk("se_busy", busy, 1);
    chk("se_cpu_reset", cpu_reset, 1);
    chk("se_dl_ready", dl_ready, 1);
    dl_valid = 1; dl_addr = 12'h020; dl_data = 8'h5A;
    @(negedge clk);
    dl_valid = 0;
    chk("se_byte_count", byte_count, 1);

    // reset mid-LOAD, with a debug grant in the same cycle whose ack is lost
    dbg_req = 1; dbg_addr = 12'h001; reset = 1;
    #1;
    chk("abort_grant_addr", rom_addr, 12'h001);
    @(negedge clk);
    reset = 0; dbg_req = 0;
    chk("abort_dbg_ack", dbg_ack, 0);
    chk("abort_dbg_data", dbg_data, 0);
    chk("abort_busy", busy, 1);
    chk("abort_dl_ready", dl_ready, 0);
    chk("abort_err", err, 0);
    chk("abort_byte_count", byte_count, 0);
    chk("abort_cpu_reset", cpu_reset, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
